// File: rtl/store_unit_pkg.sv
// Shared types and constants for the store engine: width codes, word geometry
// and the alignment rule that decides between a memory access and a rejection.
package store_unit_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_LANES = XLEN / 8;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  // Width code is legal and the byte address is naturally aligned for it.
  function automatic logic store_legal(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      SB:      store_legal = 1'b1;
      SH:      store_legal = ~a[0];
      SW:      store_legal = (a == 2'b00);
      default: store_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: splices the store data into the old memory word
// and reports which byte lanes were replaced.
module store_merge
  import store_unit_pkg::*;
(
  input  logic [XLEN-1:0]      old_word,
  input  logic [XLEN-1:0]      wdata,
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr,
  output logic [XLEN-1:0]      merged,
  output logic [NUM_LANES-1:0] be
);

  logic [NUM_LANES-1:0][7:0] old_b, wd_b, mrg_b;
  logic [1:0]                lane_mask;

  assign old_b  = old_word;
  assign wd_b   = wdata;
  assign merged = mrg_b;

  always_comb begin
    be        = '0;
    lane_mask = 2'b00;
    case (funct3)
      SB: be = 4'b0001 << addr;
      SH: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        lane_mask = 2'b01;
      end
      SW: begin
        be        = 4'b1111;
        lane_mask = 2'b11;
      end
      default: ;
    endcase
  end

  // Lane i takes source byte (i & mask): byte 0 for sb, the low half for sh.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mrg_b[i] = be[i] ? wd_b[2'(i) & lane_mask] : old_b[i];
  end

endmodule

// File: rtl/store_unit.sv
// Multicycle store engine: read-modify-write for sb/sh, direct write for sw,
// rejection pulse for illegal or misaligned requests.
module store_unit
  import store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, old_q;
  logic [2:0]  funct3_q;
  logic        accept;
  logic [31:0] merged;
  logic [3:0]  be;

  assign accept = req_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      old_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        funct3_q <= funct3;
      end
      if (state_q == READ) old_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!store_legal(funct3, addr[1:0])) state_d = ERR;
          else if (funct3 == SW)                state_d = WRITE;
          else                                  state_d = READ;
        end
      end
      READ: begin
        mem_re  = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        mem_we  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        misaligned = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  store_merge u_merge (
    .old_word (old_q),
    .wdata    (wdata_q),
    .funct3   (funct3_q),
    .addr     (addr_q[1:0]),
    .merged   (merged),
    .be       (be)
  );

  // Write-side outputs stay quiet except while the write strobe is up.
  assign mem_wdata = mem_we ? merged : '0;
  assign mem_be    = mem_we ? be : '0;
  assign mem_addr  = (state_q == IDLE) ? '0 : {addr_q[31:2], 2'b00};

endmodule
